// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage_if
// Description : Data-memory request/response bus between the MEM-stage LSU
//               (master) and the data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_stage
// Description : RV64I MEM-stage load/store unit. Issues one data-memory
//               access per instruction, packs store lanes/strobes, extracts
//               and extends load data, and stalls the pipeline meanwhile.
//               Optional macro MISALIGN_TRAP_EN: misaligned H/W/D accesses
//               are not issued and raise a one-cycle misalign_exc pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_stage #(
  parameter int unsigned RESP_TIMEOUT = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        ex_valid,
  input  wire logic        mem_read,
  input  wire logic        mem_write,
  input  wire logic [2:0]  funct3,
  input  wire logic [63:0] addr,
  input  wire logic [63:0] store_data,
  output logic             stall,
  output logic [63:0]      load_data,
  output logic             load_valid,
  output logic             store_done,
  output logic             bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic             misalign_exc,
`endif
  lsu_mem_stage_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Last WAIT-cycle count value before the response is declared lost.
  localparam logic [7:0] c_timeout_last = 8'(RESP_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [2:0]  r_off;
  logic        r_we;

  logic        w_access;
  logic        w_misaligned;
  logic [7:0]  w_size_mask;
  logic [63:0] w_lane;
  logic [63:0] w_ext;

  assign w_access = ex_valid & (mem_read | mem_write);

  // Combinational stall: hold the front of the pipe until the access retires.
  assign stall = ((r_state == ST_IDLE) && w_access) ||
                 (r_state == ST_REQ) || (r_state == ST_WAIT);

`ifdef MISALIGN_TRAP_EN
  // Natural-alignment check on the incoming access (funct3=111 counts as D).
  always_comb begin
    w_misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   w_misaligned = addr[0];
      2'b10:   w_misaligned = |addr[1:0];
      2'b11:   w_misaligned = |addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end
`else
  assign w_misaligned = 1'b0;
`endif

  // Byte-enable pattern for the access size, before lane shifting.
  always_comb begin
    w_size_mask = 8'h01;
    case (funct3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  // Pull the addressed lane down to bit 0 and extend it to 64 bits.
  assign w_lane = bus.dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_lane;
    case (r_f3)
      3'b000:  w_ext = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_ext = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_ext = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b100:  w_ext = {56'd0, w_lane[7:0]};
      3'b101:  w_ext = {48'd0, w_lane[15:0]};
      3'b110:  w_ext = {32'd0, w_lane[31:0]};
      default: w_ext = w_lane;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; rvalid wins over the timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_access) w_state_nxt = w_misaligned ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (bus.dmem_ready) w_state_nxt = r_we ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.dmem_rvalid || (r_cnt == c_timeout_last)) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= 8'd0;
      r_f3           <= 3'd0;
      r_off          <= 3'd0;
      r_we           <= 1'b0;
      load_data      <= 64'd0;
      load_valid     <= 1'b0;
      store_done     <= 1'b0;
      bus_err        <= 1'b0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= 64'd0;
      bus.dmem_wdata <= 64'd0;
      bus.dmem_wstrb <= 8'd0;
`ifdef MISALIGN_TRAP_EN
      misalign_exc   <= 1'b0;
`endif
    end else begin
      load_valid <= 1'b0;
      store_done <= 1'b0;
      bus_err    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_exc <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_f3  <= funct3;
            r_off <= addr[2:0];
            r_we  <= mem_write;
          end
          if (w_access && w_misaligned) begin
`ifdef MISALIGN_TRAP_EN
            misalign_exc <= 1'b1;
`endif
          end else if (w_access) begin
            // Lanes shifted past byte 7 simply fall off the doubleword.
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= mem_write;
            bus.dmem_addr  <= {addr[63:3], 3'b000};
            bus.dmem_wdata <= store_data << {addr[2:0], 3'b000};
            bus.dmem_wstrb <= w_size_mask << addr[2:0];
          end
        end
        ST_REQ: begin
          if (bus.dmem_ready) begin
            bus.dmem_req <= 1'b0;
            r_cnt        <= 8'd0;
            if (r_we) store_done <= 1'b1;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.dmem_rvalid) begin
            load_data  <= w_ext;
            load_valid <= 1'b1;
          end else if (r_cnt == c_timeout_last) begin
            load_data <= 64'd0;
            bus_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_stage
// Description : Directed self-checking bench for lsu_mem_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr;
  logic [63:0] store_data;
  logic        stall;
  logic [63:0] load_data;
  logic        load_valid;
  logic        store_done;
  logic        bus_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_exc;
`endif

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.RESP_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .store_done   (store_done),
    .bus_err      (bus_err),
`ifdef MISALIGN_TRAP_EN
    .misalign_exc (misalign_exc),
`endif
    .bus          (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd);
    ex_valid   = 1'b1;
    mem_write  = wr;
    mem_read   = ~wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1;
  endtask

  task automatic retire();
    ex_valid        = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    bus.dmem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  // Zero-wait request acceptance, rvalid after 'gap' empty WAIT cycles; ends in DONE.
  task automatic load_seq(input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] rd, input int gap);
    bus.dmem_ready  = 1'b1;
    bus.dmem_rvalid = 1'b0;
    issue(1'b0, f3, a, 64'd0);
    @(negedge clk);
    @(negedge clk);
    repeat (gap) @(negedge clk);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = rd;
    @(negedge clk);
  endtask

  initial begin
    int ncyc;
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 64'd0; store_data = 64'd0;
    bus.dmem_ready = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 64'd0;
    repeat (2) @(negedge clk);

    // Reset state
    chk1 ("rst_stall",      stall,          1'b0);
    chk64("rst_load_data",  load_data,      64'd0);
    chk1 ("rst_load_valid", load_valid,     1'b0);
    chk1 ("rst_store_done", store_done,     1'b0);
    chk1 ("rst_bus_err",    bus_err,        1'b0);
    chk1 ("rst_req",        bus.dmem_req,   1'b0);
    chk64("rst_addr",       bus.dmem_addr,  64'd0);
    chk64("rst_wstrb",      64'(bus.dmem_wstrb), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ex_valid with neither read nor write: no action
    ex_valid = 1'b1; #1;
    chk1("noop_stall", stall, 1'b0);
    @(negedge clk);
    chk1("noop_req", bus.dmem_req, 1'b0);
    ex_valid = 1'b0;

    // SW addr 0x1004, zero-wait
    bus.dmem_ready = 1'b1;
    issue(1'b1, 3'b010, 64'h1004, 64'hDEADBEEF);
    chk1("sw_stall_c0", stall, 1'b1);
    @(negedge clk);
    chk1 ("sw_stall_c1", stall,          1'b1);
    chk1 ("sw_req",      bus.dmem_req,   1'b1);
    chk1 ("sw_we",       bus.dmem_we,    1'b1);
    chk64("sw_addr",     bus.dmem_addr,  64'h1000);
    chk64("sw_wstrb",    64'(bus.dmem_wstrb), 64'hF0);
    chk64("sw_wdata",    bus.dmem_wdata, 64'hDEADBEEF_00000000);
    @(negedge clk);
    chk1("sw_stall_done", stall,      1'b0);
    chk1("sw_store_done", store_done, 1'b1);
    chk1("sw_req_drop",   bus.dmem_req, 1'b0);
    retire();
    chk1("sw_done_pulse_end", store_done, 1'b0);

    // SD with both read and write set: store wins
    issue(1'b1, 3'b011, 64'h1100, 64'h11223344_55667788);
    mem_read = 1'b1; #1;
    @(negedge clk);
    chk1 ("sd_we",    bus.dmem_we,    1'b1);
    chk64("sd_wstrb", 64'(bus.dmem_wstrb), 64'hFF);
    chk64("sd_wdata", bus.dmem_wdata, 64'h11223344_55667788);
    @(negedge clk);
    chk1("sd_store_done", store_done, 1'b1);
    retire();

`ifndef MISALIGN_TRAP_EN
    // SH at offset 7: upper byte lane dropped
    issue(1'b1, 3'b001, 64'h1207, 64'hABCD);
    @(negedge clk);
    chk64("sh7_wstrb", 64'(bus.dmem_wstrb), 64'h80);
    chk64("sh7_wdata", bus.dmem_wdata, 64'hCD000000_00000000);
    @(negedge clk);
    retire();
`endif

    // LB / LBU addr 0x2003, rvalid after 2 WAIT cycles
    load_seq(3'b000, 64'h2003, 64'h00000000_80000000, 2);
    chk1 ("lb_valid", load_valid, 1'b1);
    chk64("lb_data",  load_data,  64'hFFFFFFFF_FFFFFF80);
    retire();
    chk1("lb_valid_end", load_valid, 1'b0);
    load_seq(3'b100, 64'h2003, 64'h00000000_80000000, 2);
    chk64("lbu_data", load_data, 64'h80);
    retire();

    // LH / LWU on upper lanes, funct3=111 as LD
    load_seq(3'b001, 64'h6006, 64'hBEEF0000_00000000, 0);
    chk64("lh_data", load_data, 64'hFFFFFFFF_FFFFBEEF);
    chk1 ("lh_stall_done", stall, 1'b0);
    retire();
    load_seq(3'b110, 64'h7004, 64'h89ABCDEF_00000000, 0);
    chk64("lwu_data", load_data, 64'h00000000_89ABCDEF);
    retire();
    load_seq(3'b111, 64'h8000, 64'h80000000_00000001, 0);
    chk64("f3_111_data", load_data, 64'h80000000_00000001);
    retire();

    // LD with ready held low for 3 REQ cycles
    bus.dmem_ready = 1'b0;
    issue(1'b0, 3'b011, 64'h3000, 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1 ("ld_hold_req",  bus.dmem_req,  1'b1);
      chk64("ld_hold_addr", bus.dmem_addr, 64'h3000);
    end
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    chk1("ld_wait_req",   bus.dmem_req, 1'b0);
    chk1("ld_wait_stall", stall,        1'b1);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 64'h01234567_89ABCDEF;
    @(negedge clk);
    chk1 ("ld_valid", load_valid, 1'b1);
    chk64("ld_data",  load_data,  64'h01234567_89ABCDEF);
    retire();
    chk1 ("ld_valid_end", load_valid, 1'b0);
    chk64("ld_data_hold", load_data,  64'h01234567_89ABCDEF);

    // LW timeout: IDLE + REQ + 16 WAIT cycles of stall
    issue(1'b0, 3'b010, 64'h5000, 64'd0);
    ncyc = 0;
    while (stall === 1'b1 && ncyc < 100) begin
      ncyc++;
      @(negedge clk);
    end
    chk64("to_stall_cycles", 64'(ncyc), 64'd18);
    chk1 ("to_bus_err",      bus_err,    1'b1);
    chk1 ("to_no_valid",     load_valid, 1'b0);
    chk64("to_load_data",    load_data,  64'd0);
    retire();
    chk1("to_err_end",   bus_err, 1'b0);
    chk1("to_stall_end", stall,   1'b0);

    // rvalid arriving on the timeout cycle wins
    load_seq(3'b010, 64'h5008, 64'h00000000_7FFFFFFF, 15);
    chk1 ("prio_valid",  load_valid, 1'b1);
    chk1 ("prio_no_err", bus_err,    1'b0);
    chk64("prio_data",   load_data,  64'h7FFFFFFF);
    retire();

    // Reset while in WAIT
    bus.dmem_ready = 1'b1;
    issue(1'b0, 3'b011, 64'h9000, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; #1;
    chk1 ("wrst_stall", stall,         1'b0);
    chk1 ("wrst_req",   bus.dmem_req,  1'b0);
    chk64("wrst_addr",  bus.dmem_addr, 64'd0);
    chk64("wrst_data",  load_data,     64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("wrst_no_valid", load_valid, 1'b0);
    chk1("wrst_no_err",   bus_err,    1'b0);
    load_seq(3'b100, 64'h9001, 64'h00000000_00007F00, 0);
    chk1 ("post_rst_valid", load_valid, 1'b1);
    chk64("post_rst_data",  load_data,  64'h7F);
    retire();

`ifdef MISALIGN_TRAP_EN
    // Misaligned LH: trap, no bus request, load_data untouched
    issue(1'b0, 3'b001, 64'h4001, 64'd0);
    chk1("mis_stall_c0", stall, 1'b1);
    @(negedge clk);
    chk1 ("mis_exc",      misalign_exc, 1'b1);
    chk1 ("mis_no_req",   bus.dmem_req, 1'b0);
    chk1 ("mis_stall",    stall,        1'b0);
    chk1 ("mis_no_valid", load_valid,   1'b0);
    chk64("mis_data",     load_data,    64'h7F);
    retire();
    chk1("mis_exc_end", misalign_exc, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the 64-bit RV64I pipeline, directly downstream of the EX-stage ALU.
- Takes the ALU result, registered in EX/MEM, as the effective address.
- Runs a request/response handshake with the data memory, packs store bytes and strobes, and extracts/sign-extends load data.
- Stalls the pipeline while an access is outstanding.

Parameters:
- RESP_TIMEOUT, 16: max cycles in WAIT before aborting with bus_err (1..255).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  EX/MEM holds a valid instruction
- mem_read  input  1  load instruction
- mem_write  input  1  store instruction
- funct3  input  3  size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 011 LD/SD, 100 LBU, 101 LHU, 110 LWU
- addr  input  64  effective address (ALU result)
- store_data  input  64  rs2 value, data in low bytes
- stall  output  1  freeze IF..EX/MEM
- load_data  output  64  extended load result, registered
- load_valid  output  1  one-cycle pulse, load_data valid
- store_done  output  1  one-cycle pulse, store accepted
- bus_err  output  1  one-cycle pulse, response timeout
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = write
- dmem_addr  output  64  8-byte-aligned address ({addr[63:3],3'b0})
- dmem_wdata  output  64  store data shifted to byte lane
- dmem_wstrb  output  8  byte enables
- dmem_ready  input  1  memory accepts request this cycle
- dmem_rvalid  input  1  read data valid
- dmem_rdata  input  64  read data, full doubleword
- misalign_exc  output  1  (MISALIGN_TRAP_EN only) one-cycle pulse

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, timeout counter=0.
  - All registered outputs 0: load_data, load_valid, store_done, bus_err, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, misalign_exc.
  - Reset mid-transaction abandons the access; no pulse is produced.
- stall is combinational: (state==IDLE & ex_valid & (mem_read|mem_write)) | state==REQ | state==WAIT. It is 0 in DONE.
- Access kind: mem_write has priority if both mem_read and mem_write are set. ex_valid with neither set gives no action and no stall.
- IDLE:
  - On an access, latch the operation: funct3, addr[2:0], op.
  - Drive dmem_addr, dmem_we, dmem_wdata = store_data << (8*addr[2:0]), and dmem_wstrb from size (B=1, H=3, W=F, D=FF) << addr[2:0].
  - Go to REQ.
- REQ:
  - dmem_req=1, held stable until dmem_ready.
  - On ready: a store goes to DONE (store_done=1 next cycle); a load goes to WAIT and clears the counter.
  - dmem_rvalid is ignored in REQ.
- WAIT:
  - dmem_req=0; the counter increments each cycle.
  - On dmem_rvalid: select the lane dmem_rdata >> (8*addr[2:0]) and truncate to size. Sign-extend for funct3[2]=0, zero-extend for funct3[2]=1. Register into load_data, pulse load_valid, go to DONE.
  - If the counter reaches RESP_TIMEOUT with no rvalid: load_data=0, pulse bus_err, go to DONE.
  - rvalid has priority over timeout in the same cycle.
- DONE:
  - Single cycle; pulses are asserted here and load_data is stable.
  - Go to IDLE. A new request is sampled only in IDLE.
- Latency with zero-wait memory: store stalls 2 cycles (IDLE, REQ). Load stalls 3 cycles (IDLE, REQ, WAIT with rvalid in the first WAIT cycle).
- load_data holds its last value until the next load completes.
- funct3=111 is treated as LD.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - An access is misaligned if addr[0]!=0 for H, addr[1:0]!=0 for W, or addr[2:0]!=0 for D.
  - A misaligned access skips REQ and goes IDLE->DONE with no dmem_req and misalign_exc pulsed in DONE.
  - A load leaves load_data unchanged and pulses no load_valid; a store pulses no store_done.
  - stall is 1 for one cycle.
- Undefined:
  - No misalign_exc port.
  - Offsets are used as-is; lanes that fall beyond byte 7 are dropped (strobe and data truncated to 8 bytes).

Test Plan:
- SW addr=0x1004, store_data=0xDEADBEEF, ready=1 immediately -> dmem_addr=0x1000, wstrb=0xF0, wdata=0xDEADBEEF_00000000, store_done pulses; stall high exactly 2 cycles.
- LB addr=0x2003, rdata=0x00000000_80000000 after 2 WAIT cycles -> load_data=0xFFFFFFFF_FFFFFF80; LBU on the same stimulus -> 0x80.
- LD addr=0x3000, dmem_ready held low 3 cycles -> dmem_req and dmem_addr stable throughout; after rvalid with 0x0123456789ABCDEF, load_data equals it; load_valid high 1 cycle.
- LW with rvalid never asserted, RESP_TIMEOUT=16 -> bus_err pulses after 16 WAIT cycles, load_data=0, return to IDLE, stall drops.
- rst_n pulled low while in WAIT -> all outputs 0 immediately; next load after release completes normally.
- (MISALIGN_TRAP_EN) LH addr=0x4001 -> misalign_exc pulse, no dmem_req, stall high 1 cycle, load_data unchanged.
